// File: rtl/axi_lite_to_pcie_requester.sv
// AXI-Lite slave that issues PCIe MWr32/MRd32 TLPs on a 128-bit TX stream and returns CplD data.
// Optional completion timeout in RD_WAIT: define CPL_TIMEOUT_EN.
module axi_lite_to_pcie_requester #(
   parameter int          C_DATA_WIDTH  = 128,
   parameter logic [31:0] AXI_WIN_MASK  = 32'hFFFF0000,
   parameter logic [31:0] PCIE_WIN_BASE = 32'h80000000,
   parameter logic [15:0] CPL_TIMEOUT   = 16'd50000
) (
   input  logic         user_clk,
   input  logic         user_reset,
   input  logic [15:0]  requester_id,
   input  logic [31:0]  S_AXI_AWADDR,
   input  logic         S_AXI_AWVALID,
   output logic         S_AXI_AWREADY,
   input  logic [31:0]  S_AXI_WDATA,
   input  logic [3:0]   S_AXI_WSTRB,
   input  logic         S_AXI_WVALID,
   output logic         S_AXI_WREADY,
   output logic [1:0]   S_AXI_BRESP,
   output logic         S_AXI_BVALID,
   input  logic         S_AXI_BREADY,
   input  logic [31:0]  S_AXI_ARADDR,
   input  logic         S_AXI_ARVALID,
   output logic         S_AXI_ARREADY,
   output logic [31:0]  S_AXI_RDATA,
   output logic [1:0]   S_AXI_RRESP,
   output logic         S_AXI_RVALID,
   input  logic         S_AXI_RREADY,
   output logic [127:0] m_axis_tx_tdata,
   output logic [15:0]  m_axis_tx_tkeep,
   output logic [3:0]   m_axis_tx_tuser,
   output logic         m_axis_tx_tlast,
   output logic         m_axis_tx_tvalid,
   input  logic         m_axis_tx_tready,
   input  logic [127:0] s_axis_cpl_tdata,
   input  logic [15:0]  s_axis_cpl_tkeep,
   input  logic         s_axis_cpl_tlast,
   input  logic         s_axis_cpl_tvalid,
   output logic         s_axis_cpl_tready
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_WR_TLP, ST_WR_RESP, ST_RD_TLP, ST_RD_WAIT, ST_RD_RESP
   } state_t;

   state_t         r_state;
   logic           r_awready, r_wready, r_arready;
   logic           r_bvalid, r_rvalid;
   logic [31:0]    r_rdata;
   logic [1:0]     r_rresp;
   logic [127:0]   r_tx_tdata;
   logic [15:0]    r_tx_tkeep;
   logic           r_tx_tlast, r_tx_tvalid;
   logic [7:0]     r_tag;
   logic           r_last_rd;
   logic           r_cpl_tready;
   logic           r_cpl_sop;
`ifdef CPL_TIMEOUT_EN
   logic [15:0]    r_tmo;
`endif

   logic           w_wr_elig, w_rd_elig;
   logic [31:0]    w_wr_addr, w_rd_addr;
   logic [7:0]     w_tag_next;
   logic           w_cpl_hit, w_cpl_ok;
   logic           w_unused;

   function automatic logic [31:0] f_xlate(input logic [31:0] a);
      return ((a & ~AXI_WIN_MASK) | (PCIE_WIN_BASE & AXI_WIN_MASK)) & 32'hFFFF_FFFC;
   endfunction

   assign w_wr_elig  = S_AXI_AWVALID & S_AXI_WVALID;
   assign w_rd_elig  = S_AXI_ARVALID;
   assign w_wr_addr  = f_xlate(S_AXI_AWADDR);
   assign w_rd_addr  = f_xlate(S_AXI_ARADDR);
   assign w_tag_next = r_tag + 8'd1;

   // Header is only inspected on the first beat of a completion packet
   assign w_cpl_hit = s_axis_cpl_tvalid & r_cpl_tready & r_cpl_sop
                    & (s_axis_cpl_tdata[28:24] == 5'b01010)
                    & (s_axis_cpl_tdata[79:72] == r_tag);
   assign w_cpl_ok  = (s_axis_cpl_tdata[31:29] == 3'b010) & (s_axis_cpl_tdata[47:45] == 3'b000);

   assign w_unused = ^{s_axis_cpl_tkeep, s_axis_cpl_tdata[95:80], s_axis_cpl_tdata[71:64],
                       s_axis_cpl_tdata[63:48], s_axis_cpl_tdata[44:32], s_axis_cpl_tdata[23:0]};

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         r_state      <= ST_IDLE;
         r_awready    <= 1'b0;
         r_wready     <= 1'b0;
         r_arready    <= 1'b0;
         r_bvalid     <= 1'b0;
         r_rvalid     <= 1'b0;
         r_rdata      <= 32'h0;
         r_rresp      <= 2'b00;
         r_tx_tdata   <= 128'h0;
         r_tx_tkeep   <= 16'h0;
         r_tx_tlast   <= 1'b0;
         r_tx_tvalid  <= 1'b0;
         r_tag        <= 8'h0;
         r_last_rd    <= 1'b1;
         r_cpl_tready <= 1'b0;
         r_cpl_sop    <= 1'b1;
`ifdef CPL_TIMEOUT_EN
         r_tmo        <= 16'h0;
`endif
      end else begin
         r_cpl_tready <= 1'b1;
         if (s_axis_cpl_tvalid && r_cpl_tready)
            r_cpl_sop <= s_axis_cpl_tlast;

         case (r_state)
            ST_IDLE: begin
               r_awready <= 1'b0;
               r_wready  <= 1'b0;
               r_arready <= 1'b0;
               if (r_awready && w_wr_elig) begin
                  r_tx_tdata  <= {S_AXI_WDATA, w_wr_addr, requester_id, r_tag,
                                  4'h0, S_AXI_WSTRB, 32'h4000_0001};
                  r_tx_tkeep  <= 16'hFFFF;
                  r_tx_tlast  <= 1'b1;
                  r_tx_tvalid <= 1'b1;
                  r_state     <= ST_WR_TLP;
               end else if (r_arready && w_rd_elig) begin
                  r_tag       <= w_tag_next;
                  r_tx_tdata  <= {32'h0, w_rd_addr, requester_id, w_tag_next,
                                  8'h0F, 32'h0000_0001};
                  r_tx_tkeep  <= 16'h0FFF;
                  r_tx_tlast  <= 1'b1;
                  r_tx_tvalid <= 1'b1;
                  r_state     <= ST_RD_TLP;
               end else if (!r_awready && !r_arready) begin
                  // Round-robin when both channels request in the same cycle
                  if (w_wr_elig && (!w_rd_elig || r_last_rd)) begin
                     r_awready <= 1'b1;
                     r_wready  <= 1'b1;
                     r_last_rd <= 1'b0;
                  end else if (w_rd_elig) begin
                     r_arready <= 1'b1;
                     r_last_rd <= 1'b1;
                  end
               end
            end
            ST_WR_TLP: begin
               if (m_axis_tx_tready) begin
                  r_tx_tvalid <= 1'b0;
                  r_tx_tlast  <= 1'b0;
                  r_bvalid    <= 1'b1;
                  r_state     <= ST_WR_RESP;
               end
            end
            ST_WR_RESP: begin
               if (S_AXI_BREADY) begin
                  r_bvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            ST_RD_TLP: begin
               if (m_axis_tx_tready) begin
                  r_tx_tvalid <= 1'b0;
                  r_tx_tlast  <= 1'b0;
                  r_state     <= ST_RD_WAIT;
`ifdef CPL_TIMEOUT_EN
                  r_tmo       <= 16'h0;
`endif
               end
            end
            ST_RD_WAIT: begin
               if (w_cpl_hit) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= w_cpl_ok ? s_axis_cpl_tdata[127:96] : 32'hFFFF_FFFF;
                  r_rresp  <= w_cpl_ok ? 2'b00 : 2'b10;
                  r_state  <= ST_RD_RESP;
               end
`ifdef CPL_TIMEOUT_EN
               else if (r_tmo == CPL_TIMEOUT - 16'd1) begin
                  r_rvalid <= 1'b1;
                  r_rdata  <= 32'hFFFF_FFFF;
                  r_rresp  <= 2'b10;
                  r_state  <= ST_RD_RESP;
               end else begin
                  r_tmo <= r_tmo + 16'd1;
               end
`endif
            end
            ST_RD_RESP: begin
               if (S_AXI_RREADY) begin
                  r_rvalid <= 1'b0;
                  r_state  <= ST_IDLE;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign S_AXI_AWREADY     = r_awready;
   assign S_AXI_WREADY      = r_wready;
   assign S_AXI_ARREADY     = r_arready;
   assign S_AXI_BVALID      = r_bvalid;
   assign S_AXI_BRESP       = 2'b00;
   assign S_AXI_RVALID      = r_rvalid;
   assign S_AXI_RDATA       = r_rdata;
   assign S_AXI_RRESP       = r_rresp;
   assign m_axis_tx_tdata   = r_tx_tdata;
   assign m_axis_tx_tkeep   = r_tx_tkeep;
   assign m_axis_tx_tuser   = 4'b0000;
   assign m_axis_tx_tlast   = r_tx_tlast;
   assign m_axis_tx_tvalid  = r_tx_tvalid;
   assign s_axis_cpl_tready = r_cpl_tready;

endmodule

// File: tb/tb_axi_lite_to_pcie_requester.sv
// Scoreboard bench for axi_lite_to_pcie_requester: expected TLPs and read responses are queued
// when stimulus is driven and compared as the DUT emits them.
module tb_axi_lite_to_pcie_requester;

   localparam logic [15:0] RID = 16'h0108;

   logic         user_clk = 1'b0;
   logic         user_reset = 1'b1;
   logic [31:0]  S_AXI_AWADDR = '0, S_AXI_WDATA = '0, S_AXI_ARADDR = '0;
   logic [3:0]   S_AXI_WSTRB = '0;
   logic         S_AXI_AWVALID = 0, S_AXI_WVALID = 0, S_AXI_ARVALID = 0;
   logic         S_AXI_BREADY = 1, S_AXI_RREADY = 1;
   logic         S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY, S_AXI_BVALID, S_AXI_RVALID;
   logic [1:0]   S_AXI_BRESP, S_AXI_RRESP;
   logic [31:0]  S_AXI_RDATA;
   logic [127:0] m_axis_tx_tdata;
   logic [15:0]  m_axis_tx_tkeep;
   logic [3:0]   m_axis_tx_tuser;
   logic         m_axis_tx_tlast, m_axis_tx_tvalid;
   logic         m_axis_tx_tready = 1;
   logic [127:0] s_axis_cpl_tdata = '0;
   logic [15:0]  s_axis_cpl_tkeep = 16'hFFFF;
   logic         s_axis_cpl_tlast = 1, s_axis_cpl_tvalid = 0;
   logic         s_axis_cpl_tready;

   always #5 user_clk = ~user_clk;

   axi_lite_to_pcie_requester #(.CPL_TIMEOUT(16'd100)) dut (
      .user_clk(user_clk), .user_reset(user_reset), .requester_id(RID),
      .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
      .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
      .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID),
      .S_AXI_BREADY(S_AXI_BREADY), .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID),
      .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
      .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
      .m_axis_tx_tdata(m_axis_tx_tdata), .m_axis_tx_tkeep(m_axis_tx_tkeep),
      .m_axis_tx_tuser(m_axis_tx_tuser), .m_axis_tx_tlast(m_axis_tx_tlast),
      .m_axis_tx_tvalid(m_axis_tx_tvalid), .m_axis_tx_tready(m_axis_tx_tready),
      .s_axis_cpl_tdata(s_axis_cpl_tdata), .s_axis_cpl_tkeep(s_axis_cpl_tkeep),
      .s_axis_cpl_tlast(s_axis_cpl_tlast), .s_axis_cpl_tvalid(s_axis_cpl_tvalid),
      .s_axis_cpl_tready(s_axis_cpl_tready)
   );

   typedef struct packed {
      logic [15:0]  keep;
      logic [127:0] data;
   } tlp_t;

   typedef struct {
      logic [7:0]  tag;
      logic [2:0]  fmt;
      logic [2:0]  st;
      logic [31:0] data;
      logic        exp_rv;
   } cpl_t;

   tlp_t        tlp_q[$];
   logic [33:0] r_q[$];
   cpl_t        cpl_q[$];
   int          n_checks = 0;
   int          n_fail = 0;
   logic [7:0]  exp_tag = 8'h0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Default window: upper 16 bits become 0x8000, low two bits cleared
   function automatic logic [31:0] xlate(input logic [31:0] a);
      return {16'h8000, a[15:2], 2'b00};
   endfunction

   // TX monitor: every accepted beat must match the head of the expected-TLP queue
   always @(negedge user_clk) begin
      tlp_t e;
      if (!user_reset && m_axis_tx_tvalid && m_axis_tx_tready) begin
         if (tlp_q.size() == 0) begin
            check("tlp_unexpected", {127'h0, m_axis_tx_tvalid}, 128'h0);
         end else begin
            e = tlp_q.pop_front();
            check("tlp_data", m_axis_tx_tdata, e.data);
            check("tlp_keep", {112'h0, m_axis_tx_tkeep}, {112'h0, e.keep});
            check("tlp_last", {127'h0, m_axis_tx_tlast}, 128'h1);
            check("tlp_user", {124'h0, m_axis_tx_tuser}, 128'h0);
            $display("tlp  dw0=%h dw1=%h dw2=%h dw3=%h keep=%h", m_axis_tx_tdata[31:0],
                     m_axis_tx_tdata[63:32], m_axis_tx_tdata[95:64], m_axis_tx_tdata[127:96],
                     m_axis_tx_tkeep);
         end
      end
   end

   // R monitor
   always @(negedge user_clk) begin
      logic [33:0] e;
      if (!user_reset && S_AXI_RVALID && S_AXI_RREADY) begin
         if (r_q.size() == 0) begin
            check("r_unexpected", {127'h0, S_AXI_RVALID}, 128'h0);
         end else begin
            e = r_q.pop_front();
            check("r_data", {96'h0, S_AXI_RDATA}, {96'h0, e[31:0]});
            check("r_resp", {126'h0, S_AXI_RRESP}, {126'h0, e[33:32]});
            $display("read resp=%0d data=%h", S_AXI_RRESP, S_AXI_RDATA);
         end
      end
   end

   // Completer: drives queued completion beats and checks whether each one produced RVALID
   initial begin
      cpl_t c;
      forever begin
         @(posedge user_clk); #1;
         if (cpl_q.size() > 0) begin
            c = cpl_q.pop_front();
            s_axis_cpl_tdata  = {c.data, RID, c.tag, 8'h00, 16'h0100, c.st, 1'b0, 12'd4,
                                 c.fmt, 5'b01010, 14'h0, 10'd1};
            s_axis_cpl_tvalid = 1'b1;
            @(posedge user_clk); #1;
            s_axis_cpl_tvalid = 1'b0;
            @(negedge user_clk);
            check(c.exp_rv ? "cpl_rvalid_lat" : "cpl_discard", {127'h0, S_AXI_RVALID},
                  {127'h0, c.exp_rv});
            $display("cpl  tag=%h fmt=%b st=%b data=%h", c.tag, c.fmt, c.st, c.data);
         end
      end
   end

   task automatic push_cpl(input logic [7:0] t, input logic [2:0] fmt, input logic [2:0] st,
                           input logic [31:0] d, input logic rv);
      cpl_t c;
      c.tag = t; c.fmt = fmt; c.st = st; c.data = d; c.exp_rv = rv;
      cpl_q.push_back(c);
   endtask

   task automatic check_reset_state();
      check("rst_readys", {125'h0, S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}, 128'h0);
      check("rst_valids", {125'h0, S_AXI_BVALID, S_AXI_RVALID, m_axis_tx_tvalid}, 128'h0);
      check("rst_resp", {92'h0, S_AXI_BRESP, S_AXI_RRESP, S_AXI_RDATA}, 128'h0);
      check("rst_tdata", m_axis_tx_tdata, 128'h0);
      check("rst_tside", {107'h0, m_axis_tx_tkeep, m_axis_tx_tuser, m_axis_tx_tlast}, 128'h0);
      check("rst_cpl_tready", {127'h0, s_axis_cpl_tready}, 128'h0);
   endtask

   task automatic wait_beat(input string tag);
      int n = 0;
      while (!(m_axis_tx_tvalid && m_axis_tx_tready) && n < 50) begin
         @(negedge user_clk); n++;
      end
      check(tag, {127'h0, m_axis_tx_tvalid && m_axis_tx_tready}, 128'h1);
   endtask

   task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int stall);
      tlp_t e;
      int n = 0;
      logic [127:0] held;
      e.keep = 16'hFFFF;
      e.data = {d, xlate(a), RID, exp_tag, 4'h0, s, 32'h4000_0001};
      tlp_q.push_back(e);
      m_axis_tx_tready = (stall == 0);
      S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
      @(negedge user_clk);
      while (!(S_AXI_AWREADY && S_AXI_WREADY) && n < 50) begin
         @(negedge user_clk); n++;
      end
      check("wr_handshake", {126'h0, S_AXI_AWREADY, S_AXI_WREADY}, 128'h3);
      @(posedge user_clk); #1;
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      @(negedge user_clk);
      check("wr_tvalid_lat", {127'h0, m_axis_tx_tvalid}, 128'h1);
      held = m_axis_tx_tdata;
      if (stall > 0) begin
         for (int i = 1; i < stall; i++) begin
            @(negedge user_clk);
            check("wr_stall_tdata", m_axis_tx_tdata, held);
            check("wr_stall_bvalid", {127'h0, S_AXI_BVALID}, 128'h0);
         end
         @(posedge user_clk); #1;
         m_axis_tx_tready = 1;
         @(negedge user_clk);
      end
      wait_beat("wr_beat");
      @(negedge user_clk);
      check("wr_bvalid_lat", {127'h0, S_AXI_BVALID}, 128'h1);
      check("wr_bresp", {126'h0, S_AXI_BRESP}, 128'h0);
      check("wr_one_beat", {127'h0, m_axis_tx_tvalid}, 128'h0);
      @(negedge user_clk);
      check("wr_bvalid_clr", {127'h0, S_AXI_BVALID}, 128'h0);
      $display("write addr=%h data=%h strb=%h", a, d, s);
   endtask

   // kind: 0 good CplD, 1 wrong tag then UR Cpl, 2 Cpl without data, 3 none (timeout)
   task automatic do_read(input logic [31:0] a, input logic [31:0] d, input int kind,
                          input int rstall);
      tlp_t e;
      int n = 0;
      logic [31:0] held;
      exp_tag = exp_tag + 8'd1;
      e.keep = 16'h0FFF;
      e.data = {32'h0, xlate(a), RID, exp_tag, 8'h0F, 32'h0000_0001};
      tlp_q.push_back(e);
      r_q.push_back(kind == 0 ? {2'b00, d} : {2'b10, 32'hFFFF_FFFF});
      m_axis_tx_tready = 1;
      S_AXI_RREADY = (rstall == 0);
      S_AXI_ARADDR = a; S_AXI_ARVALID = 1;
      @(negedge user_clk);
      while (!S_AXI_ARREADY && n < 50) begin
         @(negedge user_clk); n++;
      end
      check("rd_handshake", {127'h0, S_AXI_ARREADY}, 128'h1);
      @(posedge user_clk); #1;
      S_AXI_ARVALID = 0;
      @(negedge user_clk);
      check("rd_tvalid_lat", {127'h0, m_axis_tx_tvalid}, 128'h1);
      wait_beat("rd_beat");
      if (kind == 0) push_cpl(exp_tag, 3'b010, 3'b000, d, 1'b1);
      if (kind == 1) begin
         push_cpl(exp_tag + 8'd1, 3'b010, 3'b000, d, 1'b0);
         push_cpl(exp_tag, 3'b000, 3'b001, 32'h0, 1'b1);
      end
      if (kind == 2) push_cpl(exp_tag, 3'b000, 3'b000, 32'h0, 1'b1);
      n = 0;
      @(negedge user_clk);
      while (!S_AXI_RVALID && n < 300) begin
         @(negedge user_clk); n++;
      end
      check("rd_rvalid", {127'h0, S_AXI_RVALID}, 128'h1);
      if (kind == 3) check("tmo_cycles", n, 100);
      if (rstall > 0) begin
         held = S_AXI_RDATA;
         for (int i = 0; i < rstall; i++) begin
            @(negedge user_clk);
            check("rd_hold_valid", {127'h0, S_AXI_RVALID}, 128'h1);
            check("rd_hold_data", {96'h0, S_AXI_RDATA}, {96'h0, held});
         end
         @(posedge user_clk); #1;
         S_AXI_RREADY = 1;
      end
      n = 0;
      while (r_q.size() > 0 && n < 50) begin
         @(negedge user_clk); n++;
      end
      check("rd_done", r_q.size(), 0);
      @(negedge user_clk);
      check("rd_rvalid_clr", {127'h0, S_AXI_RVALID}, 128'h0);
   endtask

   // AW/W and AR asserted together for two transactions each
   task automatic do_rr();
      tlp_t e;
      int n;
      int wr_left = 2;
      int rd_left = 2;
      e.keep = 16'hFFFF; e.data = {32'h1111_2222, 32'h8000_0100, RID, exp_tag, 8'h0F, 32'h4000_0001};
      tlp_q.push_back(e);
      e.keep = 16'h0FFF; e.data = {32'h0, 32'h8000_0200, RID, exp_tag + 8'd1, 8'h0F, 32'h1};
      tlp_q.push_back(e);
      e.keep = 16'hFFFF; e.data = {32'h1111_2222, 32'h8000_0100, RID, exp_tag + 8'd1, 8'h0F, 32'h4000_0001};
      tlp_q.push_back(e);
      e.keep = 16'h0FFF; e.data = {32'h0, 32'h8000_0200, RID, exp_tag + 8'd2, 8'h0F, 32'h1};
      tlp_q.push_back(e);
      r_q.push_back({2'b00, 32'h0BAD_F00D});
      r_q.push_back({2'b00, 32'h0BAD_F00D});
      m_axis_tx_tready = 1; S_AXI_BREADY = 1; S_AXI_RREADY = 1;
      S_AXI_AWADDR = 32'h0000_0100; S_AXI_WDATA = 32'h1111_2222; S_AXI_WSTRB = 4'hF;
      S_AXI_ARADDR = 32'h0000_0200;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1; S_AXI_ARVALID = 1;
      for (int g = 0; g < 4; g++) begin
         n = 0;
         @(negedge user_clk);
         while (!(S_AXI_AWREADY || S_AXI_ARREADY) && n < 50) begin
            @(negedge user_clk); n++;
         end
         check("rr_exclusive", {127'h0, S_AXI_AWREADY && S_AXI_ARREADY}, 128'h0);
         check("rr_grant", {126'h0, S_AXI_AWREADY, S_AXI_ARREADY}, (g % 2 == 0) ? 128'h2 : 128'h1);
         if (S_AXI_ARREADY) begin
            rd_left--;
            exp_tag = exp_tag + 8'd1;
            @(posedge user_clk); #1;
            if (rd_left == 0) S_AXI_ARVALID = 0;
            @(negedge user_clk);
            wait_beat("rr_rd_beat");
            push_cpl(exp_tag, 3'b010, 3'b000, 32'h0BAD_F00D, 1'b1);
            n = 0;
            while (r_q.size() > rd_left && n < 50) begin
               @(negedge user_clk); n++;
            end
            check("rr_rd_done", r_q.size(), rd_left);
         end else begin
            wr_left--;
            @(posedge user_clk); #1;
            if (wr_left == 0) begin
               S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
            end
            n = 0;
            while (!S_AXI_BVALID && n < 50) begin
               @(negedge user_clk); n++;
            end
            check("rr_bvalid", {127'h0, S_AXI_BVALID}, 128'h1);
         end
         $display("rr   grant %0d %s", g, S_AXI_ARVALID || rd_left == 0 ? "done" : "done");
      end
      @(negedge user_clk);
      check("rr_tlps_left", tlp_q.size(), 0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      repeat (4) @(negedge user_clk);
      check_reset_state();
      @(posedge user_clk); #1;
      user_reset = 0;
      repeat (2) @(negedge user_clk);
      check("cpl_tready_run", {127'h0, s_axis_cpl_tready}, 128'h1);

      do_write(32'h0000_1234, 32'hDEAD_BEEF, 4'b0011, 0);
      do_read(32'h0000_0010, 32'hCAFE_F00D, 0, 3);
      do_write(32'h00AB_CDE8, 32'h1234_5678, 4'hF, 5);
      do_write(32'hFFFF_0007, 32'h5555_AAAA, 4'h0, 0);
      do_read(32'h0000_0020, 32'h0, 1, 0);
      do_read(32'h0001_0044, 32'h0, 2, 0);
      do_rr();
`ifdef CPL_TIMEOUT_EN
      do_read(32'h0000_0030, 32'h0, 3, 0);
      push_cpl(exp_tag, 3'b010, 3'b000, 32'h7777_7777, 1'b0);
      repeat (4) @(negedge user_clk);
      do_read(32'h0000_0034, 32'h1357_9BDF, 0, 0);
`endif

      // Reset in the middle of a stalled MWr aborts it
      m_axis_tx_tready = 0;
      S_AXI_AWADDR = 32'h0000_0400; S_AXI_WDATA = 32'hA5A5_A5A5; S_AXI_WSTRB = 4'hF;
      S_AXI_AWVALID = 1; S_AXI_WVALID = 1;
      repeat (3) @(negedge user_clk);
      @(posedge user_clk); #1;
      S_AXI_AWVALID = 0; S_AXI_WVALID = 0;
      @(negedge user_clk);
      check("abort_mid_tlp", {127'h0, m_axis_tx_tvalid}, 128'h1);
      @(posedge user_clk); #1;
      user_reset = 1;
      m_axis_tx_tready = 1;
      repeat (2) @(negedge user_clk);
      check_reset_state();
      @(posedge user_clk); #1;
      user_reset = 0;
      exp_tag = 8'h0;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge user_clk);
         if (m_axis_tx_tvalid || S_AXI_BVALID) seen++;
      end
      check("abort_no_output", seen, 0);
      push_cpl(8'h00, 3'b010, 3'b000, 32'h9999_9999, 1'b0);
      repeat (5) @(negedge user_clk);
      do_read(32'h0000_0010, 32'h2468_ACE0, 0, 0);

      repeat (3) @(negedge user_clk);
      check("final_tlp_q", tlp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
